aes_inv_top: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart of the existing AES-128 encryption core: it takes a ciphertext and the same 128-bit cipher key, and returns the plaintext. It computes one round per clock. The round keys are derived on the fly: a forward key-expansion pass first produces round key 10, then the schedule is rolled backwards during decryption. It shares the encryption core's bus conventions and adds a start/busy/done handshake so a controller can sequence blocks.

---
 rtl/aes_inv_top.sv | 197 +++++++++++++++++++
 tb/tb_aes_inv_top.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_top.sv
// Iterative AES-128 inverse cipher. The key schedule is first rolled forward
// to RK10, then rolled back one step per round alongside the data path.
module aes_inv_top (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         busy,
    output logic         done
);
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);
    localparam logic [RND_W-1:0] FIRST_DEC_RND = RND_W'(9);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_t;

    // Table entry b sits at bit offset (255-b)*8, and 255-b == ~b for a byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction

    // Row r of the column-major state rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = inv_sbox(s[127-8*(4*((c-rw+4)%4)+rw) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t           state, state_d;
    logic [127:0]     st, st_d, rk, rk_d, out_d;
    logic [RND_W-1:0] rnd, rnd_d, rc_idx;
    logic             busy_d, done_d;
    logic [31:0]      key_word, key_sub;
    logic [31:0]      fw0, fw1, fw2, fw3, bw0, bw1, bw2, bw3;
    logic [127:0]     dec_sb;

    // One shared SubWord(RotWord()) serves both the forward and backward key step.
    always_comb begin
        bw3      = rk[31:0] ^ rk[63:32];
        bw2      = rk[63:32] ^ rk[95:64];
        bw1      = rk[95:64] ^ rk[127:96];
        rc_idx   = (state == INIT) ? LAST_RND : rnd;
        key_word = (state == KEYEXP) ? rk[31:0] : bw3;
        key_sub  = {sbox(key_word[23:16]), sbox(key_word[15:8]),
                    sbox(key_word[7:0]), sbox(key_word[31:24])} ^ {rcon(rc_idx), 24'h0};
        fw0      = rk[127:96] ^ key_sub;
        fw1      = rk[95:64] ^ fw0;
        fw2      = rk[63:32] ^ fw1;
        fw3      = rk[31:0] ^ fw2;
        bw0      = rk[127:96] ^ key_sub;
        dec_sb   = inv_shift_sub(st);
    end

    always_comb begin
        state_d = state;
        st_d    = st;
        rk_d    = rk;
        rnd_d   = rnd;
        out_d   = out;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    st_d    = ciphertext;
                    rk_d    = key;
                    rnd_d   = RND_W'(1);
                    state_d = KEYEXP;
                end
            end
            KEYEXP: begin
                rk_d  = {fw0, fw1, fw2, fw3};
                rnd_d = rnd + RND_W'(1);
                if (rnd == LAST_RND) state_d = INIT;
            end
            INIT: begin
                st_d    = st ^ rk;
                rk_d    = {bw0, bw1, bw2, bw3};
                rnd_d   = FIRST_DEC_RND;
                state_d = ROUND;
            end
            ROUND: begin
                st_d  = {inv_mix_col(dec_sb[127:96] ^ rk[127:96]),
                         inv_mix_col(dec_sb[95:64] ^ rk[95:64]),
                         inv_mix_col(dec_sb[63:32] ^ rk[63:32]),
                         inv_mix_col(dec_sb[31:0] ^ rk[31:0])};
                rk_d  = {bw0, bw1, bw2, bw3};
                rnd_d = rnd - RND_W'(1);
                if (rnd == RND_W'(1)) state_d = FINAL;
            end
            FINAL: begin
                out_d   = dec_sb ^ rk;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            st    <= '0;
            rk    <= '0;
            rnd   <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            st    <= st_d;
            rk    <= rk_d;
            rnd   <= rnd_d;
            out   <= out_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end
endmodule

// File: tb/tb_aes_inv_top.sv
// Directed bench for aes_inv_top: FIPS-197 vectors, handshake timing, reset
// abort, and a round trip through an independent encryption model.
module tb_aes_inv_top;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] key = '0;
    logic [127:0] out;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_top dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // S-box built from the GF(2^8) inverse plus the affine map, not from a table.
    logic [7:0] fsb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gmul(8'(x), 8'(j)) == 8'h01) inv = 8'(j);
            fsb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {fsb[tmp[23:16]], fsb[tmp[15:8]], fsb[tmp[7:0]], fsb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = fsb[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Called on a falling edge; the following rising edge is the accepting edge.
    task automatic launch(input logic [127:0] ct, input logic [127:0] k);
        ciphertext = ct;
        key        = k;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns on the falling edge where done is seen (lat = cycles since accept).
    task automatic wait_block(input bit disturb, output int lat, output int busy_cyc, output bit out_moved);
        logic [127:0] held;
        held      = out;
        lat       = -1;
        busy_cyc  = 0;
        out_moved = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (disturb && cyc == 5) begin
                start      = 1'b1;
                ciphertext = {$urandom, $urandom, $urandom, $urandom};
                key        = ~key;
            end
            if (disturb && cyc == 6) start = 1'b0;
            if (done) begin
                lat = cyc;
                break;
            end
            if (out !== held) out_moved = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int           lat, bcyc, ndone;
        bit           moved;
        logic [127:0] pt, k, ct;

        build_sbox();
        check("model_c1", aes_enc(C1_PT, C1_KEY), C1_CT);
        check("model_appb", aes_enc(B_PT, B_KEY), B_CT);

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", out, 128'h0);
        check("reset_busy", 128'(busy), 128'h0);
        check("reset_done", 128'(done), 128'h0);
        rst = 1'b1;
        @(negedge clk);

        launch(C1_CT, C1_KEY);
        wait_block(1'b0, lat, bcyc, moved);
        check("c1_latency", 128'(lat), 128'd22);
        check("c1_busy_cycles", 128'(bcyc), 128'd21);
        check("c1_out", out, C1_PT);
        check("c1_out_before_done", 128'(moved), 128'h0);

        // Back-to-back: start in the done cycle.
        launch(B_CT, B_KEY);
        wait_block(1'b0, lat, bcyc, moved);
        check("b2b_latency", 128'(lat), 128'd22);
        check("b2b_out_held", 128'(moved), 128'h0);
        check("appb_out", out, B_PT);
        @(negedge clk);
        check("done_pulse_width", 128'(done), 128'h0);
        check("busy_after_done", 128'(busy), 128'h0);
        check("out_hold", out, B_PT);

        // Start and input changes while busy are ignored.
        launch(C1_CT, C1_KEY);
        wait_block(1'b1, lat, bcyc, moved);
        check("ignore_latency", 128'(lat), 128'd22);
        check("ignore_out", out, C1_PT);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignore_single_done", 128'(ndone), 128'h0);
        check("ignore_out_hold", out, C1_PT);

        // Asynchronous reset mid-block.
        launch(B_CT, B_KEY);
        repeat (11) @(negedge clk);
        check("busy_before_reset", 128'(busy), 128'h1);
        #2 rst = 1'b0;
        #1;
        check("areset_out", out, 128'h0);
        check("areset_busy", 128'(busy), 128'h0);
        check("areset_done", 128'(done), 128'h0);
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("areset_no_done", 128'(ndone), 128'h0);
        check("areset_out_stays", out, 128'h0);
        launch(C1_CT, C1_KEY);
        wait_block(1'b0, lat, bcyc, moved);
        check("rerun_latency", 128'(lat), 128'd22);
        check("rerun_out", out, C1_PT);

        // Round trip through the encryption model.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            k  = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = aes_enc(pt, k);
            launch(ct, k);
            wait_block(1'b0, lat, bcyc, moved);
            check("roundtrip", out, pt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
